// File: rtl/reg_bank_arbiter_if.sv
// Requester and bank-side bundle for reg_bank_arbiter.
// master: requesters plus the bank model; slave: the arbiter.
interface reg_bank_arbiter_if #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [DATA_SIZE-1:0]         rsp_data;
    logic                         bank_we;
    logic                         bank_re;
    logic [ADDR_SIZE-1:0]         bank_addr;
    logic [DATA_SIZE-1:0]         bank_wdata;
    logic [DATA_SIZE-1:0]         bank_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_data, bank_rdata,
        input  req_ready, rsp_valid, rsp_data, bank_we, bank_re, bank_addr, bank_wdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, bank_rdata,
        output req_ready, rsp_valid, rsp_data, bank_we, bank_re, bank_addr, bank_wdata
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Shares one single-port register bank among NUM_REQ requesters, one transaction in flight.
// Round-robin by default; define REG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module reg_bank_arbiter #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned NUM_REQ   = 4
) (
    input logic               clk,
    input logic               rst,
    reg_bank_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, RESP} state_e;

    state_e               state_q;
    logic [PTR_W-1:0]     win_q;
    logic                 wr_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_SIZE-1:0] rsp_data_q;
    logic                 we_q;
    logic                 re_q;
    logic [ADDR_SIZE-1:0] baddr_q;
    logic [DATA_SIZE-1:0] bwdata_q;
    logic [PTR_W-1:0]     grant_c;
    logic                 found_c;

    logic [ADDR_SIZE-1:0] addr_a [NUM_REQ];
    logic [DATA_SIZE-1:0] data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = bus.req_addr[g*ADDR_SIZE +: ADDR_SIZE];
        assign data_a[g] = bus.req_data[g*DATA_SIZE +: DATA_SIZE];
    end

`ifdef REG_ARB_FIXED_PRIO_EN
    // Lowest valid index wins.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found_c && bus.req_valid[PTR_W'(k)]) begin
                grant_c = PTR_W'(k);
                found_c = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned      k);
        return PTR_W'((32'(base) + k) % NUM_REQ);
    endfunction

    // First valid index after the last granted requester.
    always_comb begin
        grant_c = ptr_q;
        found_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found_c && bus.req_valid[rr_idx(ptr_q, k)]) begin
                grant_c = rr_idx(ptr_q, k);
                found_c = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= '0;
            wr_q        <= 1'b0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            baddr_q     <= '0;
            bwdata_q    <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
            ptr_q       <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            // Pulses and bank drive default low; bank bus is only non-zero during ISSUE.
            ready_q     <= '0;
            rsp_valid_q <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            baddr_q     <= '0;
            bwdata_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        win_q   <= grant_c;
                        ready_q <= NUM_REQ'(1) << grant_c;
                        state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (bus.req_valid[win_q]) begin
                        wr_q     <= bus.req_write[win_q];
                        we_q     <= bus.req_write[win_q];
                        re_q     <= !bus.req_write[win_q];
                        baddr_q  <= addr_a[win_q];
                        bwdata_q <= bus.req_write[win_q] ? data_a[win_q] : '0;
`ifndef REG_ARB_FIXED_PRIO_EN
                        ptr_q    <= win_q;
`endif
                        state_q  <= ISSUE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        rsp_valid_q <= NUM_REQ'(1) << win_q;
                        state_q     <= RESP;
                    end else begin
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_data_q  <= bus.bank_rdata;
                    rsp_valid_q <= NUM_REQ'(1) << win_q;
                    state_q     <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.bank_we    = we_q;
    assign bus.bank_re    = re_q;
    assign bus.bank_addr  = baddr_q;
    assign bus.bank_wdata = bwdata_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: latency, reset abort, arbitration order, accept abort, wrap.
// A scoreboard of expected bank accesses and responses is checked by a negedge monitor.
module tb_reg_bank_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(NR)) bus ();

    reg_bank_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned   idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t          sb[$];
    int unsigned   grant_log[$];
    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] exp_mem [2**AW];
    int unsigned   n_asserts = 0;
    int unsigned   n_fail    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bank model: synchronous write, read data registered one cycle after bank_re.
    always @(posedge clk) begin
        if (bus.bank_we) mem[bus.bank_addr] <= bus.bank_wdata;
        if (bus.bank_re) bus.bank_rdata <= mem[bus.bank_addr];
    end

    // Monitor: bank accesses peek the scoreboard head, completions pop it.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bank_we || bus.bank_re) begin
                if (sb.size() == 0) begin
                    check("bank_unexpected", {bus.bank_we, bus.bank_re}, 2'b00);
                end else begin
                    check("bank_excl", 64'(bus.bank_we & bus.bank_re), 64'd0);
                    check("bank_dir", 64'(bus.bank_we), 64'(sb[0].wr));
                    check("bank_addr", 64'(bus.bank_addr), 64'(sb[0].addr));
                    if (sb[0].wr) check("bank_wdata", 64'(bus.bank_wdata), 64'(sb[0].data));
                end
            end else if (bus.bank_addr != '0 || bus.bank_wdata != '0) begin
                check("bank_idle_zero", {bus.bank_addr, bus.bank_wdata}, 64'd0);
            end
            if (|bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    txn_t it;
                    logic [NR-1:0] oh;
                    it = sb.pop_front();
                    oh = NR'(1) << it.idx;
                    check("rsp_idx", 64'(bus.rsp_valid), 64'(oh));
                    if (!it.wr) check("rsp_data", 64'(bus.rsp_data), 64'(it.data));
                end
            end
        end
    end

    task automatic set_req(input int unsigned i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_write[i] = wr;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Queue the expected outcome of requester i's current payload, in grant order.
    task automatic expect_txn(input int unsigned i);
        txn_t it;
        it.idx  = i;
        it.wr   = bus.req_write[i];
        it.addr = bus.req_addr[i*AW +: AW];
        it.data = it.wr ? bus.req_data[i*DW +: DW] : exp_mem[it.addr];
        if (it.wr) exp_mem[it.addr] = it.data;
        sb.push_back(it);
    endtask

    function automatic int unsigned oh_idx(input logic [NR-1:0] v);
        int unsigned r = 0;
        for (int unsigned k = 0; k < NR; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic wait_idle();
        int unsigned b = 0;
        while (sb.size() != 0 && b < 40) begin
            @(negedge clk);
            b++;
        end
        check("sb_drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Raise valids in mask; drop each after its acceptance edge unless hold.
    task automatic run_grants(input logic [NR-1:0] mask, input bit hold, input int unsigned n);
        int unsigned   got = 0;
        int unsigned   budget = 0;
        logic [NR-1:0] pend = '0;
        grant_log.delete();
        bus.req_valid = mask;
        while (got < n && budget < 200) begin
            @(negedge clk);
            budget++;
            bus.req_valid = bus.req_valid & ~pend;
            pend = '0;
            if (|bus.req_ready) begin
                grant_log.push_back(oh_idx(bus.req_ready));
                got++;
                if (!hold) pend = bus.req_ready;
            end
        end
        check("grant_count", 64'(got), 64'(n));
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();
    endtask

    initial begin
        int unsigned ord4[5];
        int unsigned ord2[2];
        txn_t        t1;

        for (int i = 0; i < 2**AW; i++) begin
            mem[i]     = '0;
            exp_mem[i] = '0;
        end
        bus.bank_rdata = '0;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.bank_we,
                                bus.bank_re, bus.bank_addr, bus.bank_wdata}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single write, requester 0.
        set_req(0, 1'b1, 4'd3, 16'hBEEF);
        expect_txn(0);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("w_ready_T1", 64'(bus.req_ready), 64'h1);
        check("w_we_T1", 64'(bus.bank_we), 64'd0);
        @(negedge clk);
        check("w_ready_T2", 64'(bus.req_ready), 64'h0);
        check("w_issue_T2", {bus.bank_we, bus.bank_re, bus.bank_addr, bus.bank_wdata},
              {1'b1, 1'b0, 4'd3, 16'hBEEF});
        bus.req_valid = '0;
        @(negedge clk);
        check("w_rsp_T3", 64'(bus.rsp_valid), 64'h1);
        check("w_we_T3", 64'(bus.bank_we), 64'd0);
        wait_idle();

        // Single read, requester 2.
        set_req(2, 1'b0, 4'd3, 16'h0000);
        expect_txn(2);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("r_ready_T1", 64'(bus.req_ready), 64'h4);
        @(negedge clk);
        check("r_issue_T2", {bus.bank_we, bus.bank_re, bus.bank_addr}, {1'b0, 1'b1, 4'd3});
        bus.req_valid = '0;
        @(negedge clk);
        check("r_rsp_T3", 64'(bus.rsp_valid), 64'h0);
        @(negedge clk);
        check("r_rsp_T4", {bus.rsp_valid, bus.rsp_data}, {4'b0100, 16'hBEEF});
        wait_idle();

        // Reset during a write ISSUE cycle.
        set_req(1, 1'b1, 4'd5, 16'h1234);
        t1.idx = 1; t1.wr = 1'b1; t1.addr = 4'd5; t1.data = 16'h1234;
        sb.push_back(t1);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("rst_ready", 64'(bus.req_ready), 64'h2);
        @(negedge clk);
        check("rst_we_before", 64'(bus.bank_we), 64'd1);
        rst = 1'b1;
        bus.req_valid = '0;
        #1;
        check("rst_async", {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.bank_we,
                            bus.bank_re, bus.bank_addr, bus.bank_wdata}, 64'd0);
        @(negedge clk);
        sb.delete();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_write", 64'(mem[5]), 64'd0);

        // All four valid continuously from the reset pointer.
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b1, AW'(8 + i), DW'(16'hA000 + i));
`ifdef REG_ARB_FIXED_PRIO_EN
        ord4 = '{0, 0, 0, 0, 0};
`else
        ord4 = '{0, 1, 2, 3, 0};
`endif
        for (int unsigned i = 0; i < 5; i++) expect_txn(ord4[i]);
        run_grants(4'b1111, 1'b1, 5);
        for (int unsigned i = 0; i < grant_log.size() && i < 5; i++)
            check($sformatf("order4_%0d", i), 64'(grant_log[i]), 64'(ord4[i]));

        // Requester 1 withdraws during ACCEPT.
        set_req(1, 1'b1, 4'd4, 16'h0F0F);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("abort_ready", 64'(bus.req_ready), 64'h2);
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_%0d", i),
                  {bus.req_ready, bus.rsp_valid, bus.bank_we, bus.bank_re}, 64'd0);
        end
        set_req(3, 1'b1, 4'd6, 16'h3333);
        expect_txn(1);
        expect_txn(3);
        ord2 = '{1, 3};
        run_grants(4'b1010, 1'b0, 2);
        for (int unsigned i = 0; i < grant_log.size() && i < 2; i++)
            check($sformatf("abort_order_%0d", i), 64'(grant_log[i]), 64'(ord2[i]));

        // Pointer at 3: requester 0 wins before 3.
        set_req(0, 1'b0, 4'd9, 16'h0000);
        set_req(3, 1'b1, 4'd2, 16'h5A5A);
        expect_txn(0);
        expect_txn(3);
        ord2 = '{0, 3};
        run_grants(4'b1001, 1'b0, 2);
        for (int unsigned i = 0; i < grant_log.size() && i < 2; i++)
            check($sformatf("wrap_order_%0d", i), 64'(grant_log[i]), 64'(ord2[i]));
        check("wrap_mem", 64'(mem[2]), 64'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
